// File: rtl/curtain_pkg.sv
// Shared types and helpers for the black screen-transition curtain.
// Holds the frame FSM encoding, default screen size and the tooth-edge test.
package curtain_pkg;

  typedef enum logic [1:0] {IDLE, CLOSING, HOLD, OPENING} curtain_state_t;

  localparam int unsigned SCREEN_W_DEF = 640;
  localparam int unsigned SCREEN_H_DEF = 480;

  // The tooth band sits directly below the body, one square tall, on alternate squares.
  function automatic logic is_tooth(input logic [10:0] x, input logic [10:0] y,
                                    input logic [10:0] rows, input logic [3:0] edge_log2);
    logic [10:0] edge_sq;
    logic [10:0] lim;
    edge_sq = 11'(1) << edge_log2;
    lim     = rows + edge_sq;
    return (rows != '0) && (y >= rows) && (y < lim) && x[edge_log2];
  endfunction

endpackage

// File: rtl/black_curtain_ctrl.sv
// Black curtain generator: closes top-to-bottom with a square-toothed edge, holds, then reopens.
// Shape only changes at start of frame; per-pixel request is registered (1-cycle latency).
module black_curtain_ctrl
  import curtain_pkg::*;
#(
  parameter int unsigned SCREEN_W    = SCREEN_W_DEF,
  parameter int unsigned SCREEN_H    = SCREEN_H_DEF,
  parameter int unsigned STEP        = 8,
  parameter int unsigned HOLD_FRAMES = 60,
  parameter int unsigned EDGE_SQ     = 16,
  parameter logic [7:0]  BLACK_COLOR = 8'h00
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_start_of_frame,
  input  logic [10:0] i_pixel_x,
  input  logic [10:0] i_pixel_y,
  input  logic        i_close_req,
  input  logic        i_abort_req,
  output logic        o_black_req,
  output logic [7:0]  o_black_rgb,
  output logic        o_screen_covered,
  output logic        o_transition_done
);

  localparam int unsigned EDGE_LOG2 = $clog2(EDGE_SQ);
  localparam int unsigned HOLD_W    = (HOLD_FRAMES > 1) ? $clog2(HOLD_FRAMES) : 1;

  localparam logic [10:0]       STEP_V    = 11'(STEP);
  localparam logic [10:0]       H_V       = 11'(SCREEN_H);
  localparam logic [10:0]       W_V       = 11'(SCREEN_W);
  localparam logic [3:0]        EDGE_L_V  = 4'(EDGE_LOG2);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_FRAMES - 1);

  curtain_state_t    r_state, w_state_d;
  logic [10:0]       r_cover_rows, w_cover_d;
  logic [HOLD_W-1:0] r_hold_cnt, w_hold_d;
  logic              r_pending, w_pending_d;
  logic              r_done, w_done_d;
  logic              r_black_req;
  logic [7:0]        r_black_rgb;

  logic [11:0] w_sum;
  logic [10:0] w_add;
  logic [10:0] w_sub;
  logic        w_inside;
  logic        w_body;
  logic        w_tooth;

  // Saturating one-frame steps of the curtain height.
  always_comb begin
    w_sum = {1'b0, r_cover_rows} + {1'b0, STEP_V};
    w_add = (w_sum >= {1'b0, H_V}) ? H_V : w_sum[10:0];
    w_sub = (r_cover_rows <= STEP_V) ? 11'd0 : (r_cover_rows - STEP_V);
  end

  always_comb begin
    w_state_d   = r_state;
    w_cover_d   = r_cover_rows;
    w_hold_d    = r_hold_cnt;
    w_pending_d = r_pending;
    w_done_d    = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (i_close_req) w_pending_d = 1'b1;
        if (i_start_of_frame && r_pending) begin
          w_pending_d = 1'b0;
          w_cover_d   = w_add;
          if (w_add == H_V) begin
            w_state_d = HOLD;
            w_hold_d  = '0;
          end else begin
            w_state_d = CLOSING;
          end
        end
      end
      CLOSING: begin
        if (i_start_of_frame) begin
          if (i_abort_req) begin
            w_cover_d = w_sub;
            w_state_d = (w_sub == '0) ? IDLE : OPENING;
            w_done_d  = (w_sub == '0);
          end else begin
            w_cover_d = w_add;
            if (w_add == H_V) begin
              w_state_d = HOLD;
              w_hold_d  = '0;
            end
          end
        end
      end
      HOLD: begin
        // Leaving HOLD already removes the first STEP rows, mirroring how CLOSING starts.
        if (i_start_of_frame) begin
          if (i_abort_req || (r_hold_cnt == HOLD_LAST)) begin
            w_cover_d = w_sub;
            w_state_d = (w_sub == '0) ? IDLE : OPENING;
            w_done_d  = (w_sub == '0);
          end else begin
            w_hold_d = r_hold_cnt + 1'b1;
          end
        end
      end
      OPENING: begin
        if (i_start_of_frame) begin
          w_cover_d = w_sub;
          if (w_sub == '0) begin
            w_state_d = IDLE;
            w_done_d  = 1'b1;
          end
        end
      end
      default: w_state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state      <= IDLE;
      r_cover_rows <= '0;
      r_hold_cnt   <= '0;
      r_pending    <= 1'b0;
      r_done       <= 1'b0;
    end else begin
      r_state      <= w_state_d;
      r_cover_rows <= w_cover_d;
      r_hold_cnt   <= w_hold_d;
      r_pending    <= w_pending_d;
      r_done       <= w_done_d;
    end
  end

  always_comb begin
    w_inside = (i_pixel_x < W_V) && (i_pixel_y < H_V);
    w_body   = (i_pixel_y < r_cover_rows);
    w_tooth  = is_tooth(i_pixel_x, i_pixel_y, r_cover_rows, EDGE_L_V);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_black_req <= 1'b0;
      r_black_rgb <= 8'h00;
    end else begin
      r_black_req <= w_inside && (w_body || w_tooth);
      r_black_rgb <= BLACK_COLOR;
    end
  end

  assign o_black_req       = r_black_req;
  assign o_black_rgb       = r_black_rgb;
  assign o_screen_covered  = (r_state == HOLD);
  assign o_transition_done = r_done;

endmodule
